// File: rtl/alg_arith_pkg.sv
// Shared definitions for the algorithmic multiplier/divider pair:
// common one-hot state typing and the default operand width.
package alg_arith_pkg;

    localparam int TAMANYO_DEF = 32;

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        ADD   = 4'b0010,
        SHIFT = 4'b0100,
        FIN   = 4'b1000
    } alg_state_e;

endpackage

// File: rtl/valor_absoluto.sv
// Combinational two's-complement magnitude; -2^(N-1) maps exactly to 2^(N-1)
// when the result is read as unsigned.
module valor_absoluto
    import alg_arith_pkg::*;
#(
    parameter int tamanyo = TAMANYO_DEF
) (
    input  logic [tamanyo-1:0] x,
    output logic [tamanyo-1:0] mag,
    output logic               sign
);

    assign sign = x[tamanyo-1];
    assign mag  = sign ? (~x + tamanyo'(1)) : x;

endmodule

// File: rtl/multiplicador_algoritmico.sv
// Sequential signed shift-add multiplier with addend: Prod = A*B + C,
// one multiplier bit per ADD/SHIFT pair, sign applied once at FIN.
module multiplicador_algoritmico
    import alg_arith_pkg::*;
#(
    parameter int tamanyo = TAMANYO_DEF
) (
    input  logic                   CLK,
    input  logic                   RSTa,
    input  logic                   Start,
    input  logic [tamanyo-1:0]     A,
    input  logic [tamanyo-1:0]     B,
    input  logic [tamanyo-1:0]     C,
    output logic [2*tamanyo-1:0]   Prod,
    output logic                   Done,
    output logic                   Busy
);

    localparam int N  = tamanyo;
    localparam int P  = 2 * tamanyo;
    localparam int CW = $clog2(tamanyo);

    alg_state_e    state_q, state_d;
    logic [N-1:0]  ma_q, ma_d, qb_q, qb_d, cr_q, cr_d;
    logic [N:0]    accu_q, accu_d;
    logic [CW-1:0] cont_q, cont_d;
    logic          sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic [P-1:0]  prod_q, prod_d;
    logic          done_q, done_d;

    logic [N-1:0]  mag_a, mag_b;
    logic          sgn_a, sgn_b;
    logic [P-1:0]  mag;

    valor_absoluto #(.tamanyo(N)) u_abs_a (.x(A), .mag(mag_a), .sign(sgn_a));
    valor_absoluto #(.tamanyo(N)) u_abs_b (.x(B), .mag(mag_b), .sign(sgn_b));

    // Low product bits accumulate in QB as the multiplier bits shift out.
    assign mag = {accu_q[N-1:0], qb_q};

    always_comb begin
        state_d  = state_q;
        ma_d     = ma_q;
        qb_d     = qb_q;
        cr_d     = cr_q;
        accu_d   = accu_q;
        cont_d   = cont_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        prod_d   = prod_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    sign_a_d = sgn_a;
                    sign_b_d = sgn_b;
                    ma_d     = mag_a;
                    qb_d     = mag_b;
                    cr_d     = C;
                    accu_d   = '0;
                    cont_d   = CW'(N - 1);
                    state_d  = ADD;
                end
            end
            ADD: begin
                if (qb_q[0])
                    accu_d = accu_q + {1'b0, ma_q};
                state_d = SHIFT;
            end
            SHIFT: begin
                {accu_d, qb_d} = {accu_q, qb_q} >> 1;
                cont_d  = cont_q - CW'(1);
                state_d = (cont_q == '0) ? FIN : ADD;
            end
            FIN: begin
                prod_d  = ((sign_a_q ^ sign_b_q) ? (~mag + P'(1)) : mag)
                          + {{N{cr_q[N-1]}}, cr_q};
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            state_q  <= IDLE;
            ma_q     <= '0;
            qb_q     <= '0;
            cr_q     <= '0;
            accu_q   <= '0;
            cont_q   <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            prod_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ma_q     <= ma_d;
            qb_q     <= qb_d;
            cr_q     <= cr_d;
            accu_q   <= accu_d;
            cont_q   <= cont_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            prod_q   <= prod_d;
            done_q   <= done_d;
        end
    end

    assign Prod = prod_q;
    assign Done = done_q;
    assign Busy = (state_q != IDLE);

`ifndef SYNTHESIS
    // Golden product captured when an operation is accepted.
    logic signed [P-1:0] model_q, model_d;

    always_comb begin
        model_d = model_q;
        if (state_q == IDLE && Start)
            model_d = P'($signed(A)) * P'($signed(B)) + P'($signed(C));
    end

    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) model_q <= '0;
        else       model_q <= model_d;
    end

    a_start_busy: assert property (@(posedge CLK) disable iff (!RSTa) !(Start && Busy))
        else $warning("Start ignored while Busy");
    a_done_prod: assert property (@(posedge CLK) disable iff (!RSTa)
        Done |-> ($signed(Prod) == model_q));
    a_done_pulse: assert property (@(posedge CLK) disable iff (!RSTa) Done |=> !Done);
`endif

endmodule
